// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int         OVERSAMPLE            = 16;
  localparam logic [3:0] MID_SAMPLE            = 4'd7;
  localparam int         DEFAULT_CLKS_PER_TICK = 13;

  // Even-parity bit for a payload zero-extended to 8 bits.
  function automatic logic even_parity_bit(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte delivery port of the UART receiver: valid/ready byte plus error pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output overrun_err
  );

  modport slave (
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  overrun_err
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Oversample tick enable: one-clk pulse every CLKS_PER_TICK clocks, restartable by realign.
module uart_tick_gen #(
  parameter int CLKS_PER_TICK = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic realign,
  output logic tick
);
  localparam int             CNT_W = $clog2(CLKS_PER_TICK);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_TICK - 1);

  logic [CNT_W-1:0] cnt_r;

  // Tick counter, zeroed on realign so the first tick lands a full period later
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (realign || cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = (cnt_r == LAST) && !realign;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 16x-oversampled UART receiver delivering bytes through a valid/ready buffer.
// Define UART_RX_PARITY_EN to receive an even parity bit and drive parity_err.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
  parameter int DATA_BITS     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_i,
  uart_rx_ctrl_if.master bus
);
  localparam int         IDX_W    = $clog2(OVERSAMPLE);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t  AFTER_DATA = PARITY;
`else
  localparam rx_state_t  AFTER_DATA = STOP;
`endif

  rx_state_t            state_r, next_state_s;
  logic                 sync1_r, sync2_r, prev_r, armed_r;
  logic [1:0]           fill_r;
  logic                 rx_s, start_s, tick_s, realign_s, mid_s;
  logic [IDX_W-1:0]     idx_r;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r, data_r;
  logic                 valid_r, frame_err_r, overrun_err_r;
  logic                 shift_en_s, start_ok_s, done_ok_s, ferr_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_chk_s, perr_s, perr_pend_r, parity_err_r;
`endif

  // Synchronizer, edge-detect flop and post-reset arming
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      fill_r  <= 2'd0;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (fill_r != 2'd2) fill_r <= fill_r + 2'd1;
      // a line still low after reset needs a genuine high before a start counts
      if (fill_r == 2'd2 && sync2_r) armed_r <= 1'b1;
    end
  end

  assign rx_s      = sync2_r;
  assign start_s   = armed_r && prev_r && !rx_s;
  assign realign_s = (state_r == IDLE) && start_s;
  assign mid_s     = tick_s && (idx_r == MID_SAMPLE);

  uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .realign (realign_s),
    .tick    (tick_s)
  );

  // Oversample index within the current bit
  always_ff @(posedge clk) begin
    if (reset || realign_s) begin
      idx_r <= '0;
    end else if (tick_s) begin
      idx_r <= idx_r + IDX_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:      if (start_s) next_state_s = START; else next_state_s = IDLE;
      START:     if (mid_s) next_state_s = rx_s ? IDLE : DATA; else next_state_s = START;
      DATA:      if (mid_s && bit_cnt_r == LAST_BIT) next_state_s = AFTER_DATA;
                 else next_state_s = DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:    if (mid_s) next_state_s = STOP; else next_state_s = PARITY;
`endif
      STOP:      if (mid_s) next_state_s = rx_s ? IDLE : WAIT_IDLE; else next_state_s = STOP;
      WAIT_IDLE: if (rx_s) next_state_s = IDLE; else next_state_s = WAIT_IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    shift_en_s = 1'b0;
    start_ok_s = 1'b0;
    done_ok_s  = 1'b0;
    ferr_s     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk_s  = 1'b0;
    perr_s     = 1'b0;
`endif
    case (state_r)
      START:   start_ok_s = mid_s && !rx_s;
      DATA:    shift_en_s = mid_s;
`ifdef UART_RX_PARITY_EN
      PARITY:  par_chk_s  = mid_s;
`endif
      STOP: begin
        done_ok_s = mid_s && rx_s;
        ferr_s    = mid_s && !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_s    = mid_s && rx_s && perr_pend_r;
`endif
      end
      default: shift_en_s = 1'b0;
    endcase
  end

  // Payload shift register (LSB first, shifts right) and bit count
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r   <= '0;
      bit_cnt_r <= 4'd0;
    end else if (start_ok_s) begin
      bit_cnt_r <= 4'd0;
    end else if (shift_en_s) begin
      shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
      bit_cnt_r <= bit_cnt_r + 4'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch held until the stop-bit sample
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_pend_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (par_chk_s) perr_pend_r <= rx_s ^ even_parity_bit(8'(shift_r));
      parity_err_r <= perr_s;
    end
  end
  assign bus.parity_err = parity_err_r;
`endif

  // Output buffer: load on completion, drop on overrun, clear on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r        <= '0;
      valid_r       <= 1'b0;
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      frame_err_r   <= ferr_s;
      overrun_err_r <= 1'b0;
      if (done_ok_s) begin
        if (!valid_r || bus.rx_ready) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else begin
          overrun_err_r <= 1'b1;
        end
      end else if (valid_r && bus.rx_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = data_r;
  assign bus.rx_valid    = valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame-level model plus directed scenarios.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int C    = 2;
  localparam int DB   = 8;
  localparam int BITP = 16 * C;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif
  // edges from driving the start bit to the edge that completes the frame:
  // 3 sync/detect clocks, half a bit to mid-start, then NB+1 whole bits
  localparam int DONE_LAT = 3 + 8 * C + BITP * (NB + 1);

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       ok;
  } frame_t;

  logic clk;
  logic reset;
  logic rx_i;
  int   cyc = 0;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_rx_ctrl #(.CLKS_PER_TICK(C), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_i  (rx_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: each queued frame completes at a known edge
  frame_t     exp_q[$];
  int         m_edge  = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;

  always @(posedge clk) begin
    frame_t f;
    m_edge = m_edge + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].t == m_edge) begin
        f = exp_q.pop_front();
        if (!f.ok) m_ferr = 1'b1;
        else if (!m_valid || bus.rx_ready) begin
          m_valid = 1'b1;
          m_data  = f.d;
        end else m_ovr = 1'b1;
      end else if (m_valid && bus.rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process plus event counters used by the directed checks
  int         rises = 0, vhigh = 0, ferrs = 0, ovrs = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_data  = 8'h00;

  always @(negedge clk) begin
    check("rx_valid", 32'(bus.rx_valid), 32'(m_valid));
    check("rx_data", 32'(bus.rx_data), 32'(m_data));
    check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
    check("overrun_err", 32'(bus.overrun_err), 32'(m_ovr));
    if (bus.rx_valid === 1'b1 && !prev_valid) rises++;
    if (bus.rx_valid === 1'b1) begin
      vhigh++;
      last_data = bus.rx_data;
    end
    if (bus.frame_err === 1'b1) ferrs++;
    if (bus.overrun_err === 1'b1) ovrs++;
    prev_valid = (bus.rx_valid === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame; optionally pulse rx_ready on exactly the completion edge
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit pulse_ready);
    logic   bits[NB+2];
    frame_t f;
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
    bits[DB + 1] = ^d;
`endif
    bits[NB + 1] = stop;
    f.t  = cyc + DONE_LAT;
    f.d  = d;
    f.ok = stop;
    exp_q.push_back(f);
    for (int j = 0; j < NB + 2; j++) begin
      rx_i = bits[j];
      for (int k = 0; k < BITP; k++) begin
        if (pulse_ready) begin
          if (cyc == f.t - 1) bus.rx_ready = 1'b1;
          else if (cyc == f.t) bus.rx_ready = 1'b0;
        end
        step();
      end
    end
  endtask

  int r0, v0, f0, o0;

  initial begin
    reset        = 1'b1;
    rx_i         = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (5) step();
    check("reset_valid", 32'(bus.rx_valid), 32'h0);
    check("reset_data", 32'(bus.rx_data), 32'h0);
    reset = 1'b0;
    repeat (20) step();

    // 1: single byte with consumer always ready
    r0 = rises; v0 = vhigh; f0 = ferrs; o0 = ovrs;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) step();
    check("t1_rises", 32'(rises - r0), 32'd1);
    check("t1_high_clks", 32'(vhigh - v0), 32'd1);
    check("t1_data", 32'(last_data), 32'hA5);
    check("t1_errs", 32'(ferrs - f0 + ovrs - o0), 32'd0);

    // 2: false start, then a real byte
    r0 = rises;
    rx_i = 1'b0;
    repeat (8) step();
    rx_i = 1'b1;
    repeat (3 * BITP) step();
    check("t2_no_byte", 32'(rises - r0), 32'd0);
    check("t2_idle", 32'(dut.state_r), 32'(IDLE));
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (10) step();
    check("t2_rises", 32'(rises - r0), 32'd1);
    check("t2_data", 32'(last_data), 32'h3C);

    // 3: framing error followed by a held break
    r0 = rises; f0 = ferrs;
    send_frame(8'h81, 1'b0, 1'b0);
    repeat (100) step();
    check("t3_ferr_pulses", 32'(ferrs - f0), 32'd1);
    check("t3_no_byte", 32'(rises - r0), 32'd0);
    check("t3_wait_idle", 32'(dut.state_r), 32'(WAIT_IDLE));
    rx_i = 1'b1;
    repeat (2 * BITP) step();
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (10) step();
    check("t3_data", 32'(last_data), 32'h55);
    check("t3_ferr_total", 32'(ferrs - f0), 32'd1);

    // 4: overrun while the consumer stalls
    bus.rx_ready = 1'b0;
    o0 = ovrs;
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (BITP) step();
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (10) step();
    check("t4_data_kept", 32'(last_data), 32'h11);
    check("t4_overrun", 32'(ovrs - o0), 32'd1);
    check("t4_valid_held", 32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    step();
    check("t4_valid_drop", 32'(bus.rx_valid), 32'h0);
    bus.rx_ready = 1'b0;

    // 5: ready exactly on the completion edge replaces the buffered byte
    o0 = ovrs;
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (BITP) step();
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (10) step();
    check("t5_data", 32'(last_data), 32'h22);
    check("t5_no_overrun", 32'(ovrs - o0), 32'd0);
    check("t5_valid", 32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    repeat (4) step();

    // 6: reset in the middle of 0xF0 with the line low
    r0 = rises; f0 = ferrs;
    rx_i = 1'b0;
    repeat (3 * BITP + BITP / 2) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (BITP) step();
    check("t6_valid", 32'(bus.rx_valid), 32'h0);
    check("t6_data", 32'(bus.rx_data), 32'h0);
    check("t6_idle", 32'(dut.state_r), 32'(IDLE));
    rx_i = 1'b1;
    repeat (2 * BITP) step();
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (10) step();
    check("t6_rises", 32'(rises - r0), 32'd1);
    check("t6_data_rx", 32'(last_data), 32'h0F);
    check("t6_no_ferr", 32'(ferrs - f0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
